// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel-strobe divider, h/v position counters, and sync,
// blanking and start-of-line/frame flags aligned with the current position.
module vga_timing_gen #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int HSYNC_POL = 0,
  parameter int VSYNC_POL = 0,
  parameter int CLK_DIV   = 1,
  parameter int CNT_W     = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  output logic             pix_en,
  output logic [CNT_W-1:0] hpos,
  output logic [CNT_W-1:0] vpos,
  output logic             hsync,
  output logic             vsync,
  output logic             display_on,
  output logic             vblank,
  output logic             line_start,
  output logic             frame_start,
  output logic [7:0]       frame_cnt
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_DISPLAY);
  localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_DISPLAY);

  // Index 0 is the horizontal axis, index 1 the vertical axis.
  localparam logic [1:0][CNT_W-1:0] SYNC_BEG = {CNT_W'(V_DISPLAY + V_FRONT),
                                                CNT_W'(H_DISPLAY + H_FRONT)};
  localparam logic [1:0][CNT_W-1:0] SYNC_END = {CNT_W'(V_DISPLAY + V_FRONT + V_SYNC),
                                                CNT_W'(H_DISPLAY + H_FRONT + H_SYNC)};
  localparam logic [1:0]            SYNC_ON  = {1'(VSYNC_POL), 1'(HSYNC_POL)};

  logic [DIV_W-1:0]      div_reg;
  logic [CNT_W-1:0]      hpos_reg, vpos_reg;
  logic [CNT_W-1:0]      h_next, v_next;
  logic [1:0][CNT_W-1:0] pos_next;
  logic [1:0]            sync_win;
  logic [1:0]            sync_reg;
  logic                  display_on_reg, vblank_reg;
  logic                  line_flag_reg, frame_flag_reg;
  logic [7:0]            frame_cnt_reg;
  logic                  frame_wrap;

  assign pix_en = run & ~reset & (div_reg == DIV_LAST);

  always_comb begin
    h_next     = hpos_reg;
    v_next     = vpos_reg;
    frame_wrap = 1'b0;
    if (pix_en) begin
      if (hpos_reg == H_LAST) begin
        h_next = '0;
        if (vpos_reg == V_LAST) begin
          v_next     = '0;
          frame_wrap = 1'b1;
        end else begin
          v_next = vpos_reg + CNT_W'(1);
        end
      end else begin
        h_next = hpos_reg + CNT_W'(1);
      end
    end
  end

  assign pos_next = {v_next, h_next};

  // Decode from the next position so the registered flags line up with hpos/vpos.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_sync
      assign sync_win[gi] = (pos_next[gi] >= SYNC_BEG[gi]) && (pos_next[gi] < SYNC_END[gi]);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      div_reg        <= '0;
      hpos_reg       <= H_LAST;
      vpos_reg       <= V_LAST;
      sync_reg       <= ~SYNC_ON;
      display_on_reg <= 1'b0;
      vblank_reg     <= 1'b1;
      line_flag_reg  <= 1'b0;
      frame_flag_reg <= 1'b0;
      frame_cnt_reg  <= '0;
    end else begin
      if (run) begin
        div_reg <= (div_reg == DIV_LAST) ? '0 : div_reg + DIV_W'(1);
      end
      hpos_reg       <= h_next;
      vpos_reg       <= v_next;
      sync_reg       <= sync_win ~^ SYNC_ON;
      display_on_reg <= (h_next < H_ACT) && (v_next < V_ACT);
      vblank_reg     <= (v_next >= V_ACT);
      line_flag_reg  <= (h_next == '0);
      frame_flag_reg <= (h_next == '0) && (v_next == '0);
      if (frame_wrap) begin
        frame_cnt_reg <= frame_cnt_reg + 8'd1;
      end
    end
  end

  // Position flags are held for the whole pixel; qualifying with the strobe
  // yields one clk per pixel and drops the pulses while frozen.
  assign line_start  = line_flag_reg & pix_en;
  assign frame_start = frame_flag_reg & pix_en;

  assign hpos       = hpos_reg;
  assign vpos       = vpos_reg;
  assign hsync      = sync_reg[0];
  assign vsync      = sync_reg[1];
  assign display_on = display_on_reg;
  assign vblank     = vblank_reg;
  assign frame_cnt  = frame_cnt_reg;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a tiny 14x7 raster: a per-cycle scoreboard for the
// base instance, plus divider-by-3 and positive-polarity/frame-wrap instances.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Base instance: CLK_DIV=1, active-low syncs
  logic        reset0 = 1'b1, run0 = 1'b0;
  logic        pe0, hs0, vs0, de0, vb0, ls0, fs0;
  logic [10:0] h0, v0;
  logic [7:0]  fc0;

  // Divide-by-3 instance
  logic        reset3 = 1'b1, run3 = 1'b0;
  logic        pe3, hs3, vs3, de3, vb3, ls3, fs3;
  logic [10:0] h3, v3;
  logic [7:0]  fc3;

  // Positive-polarity instance
  logic        resetp = 1'b1, runp = 1'b0;
  logic        pep, hsp, vsp, dep, vbp, lsp, fsp;
  logic [10:0] hp, vp;
  logic [7:0]  fcp;

  vga_timing_gen #(.H_DISPLAY(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
                   .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
                   .HSYNC_POL(0), .VSYNC_POL(0), .CLK_DIV(1), .CNT_W(11)) dut0 (
    .clk(clk), .reset(reset0), .run(run0), .pix_en(pe0), .hpos(h0), .vpos(v0),
    .hsync(hs0), .vsync(vs0), .display_on(de0), .vblank(vb0),
    .line_start(ls0), .frame_start(fs0), .frame_cnt(fc0));

  vga_timing_gen #(.H_DISPLAY(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
                   .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
                   .HSYNC_POL(0), .VSYNC_POL(0), .CLK_DIV(3), .CNT_W(11)) dut3 (
    .clk(clk), .reset(reset3), .run(run3), .pix_en(pe3), .hpos(h3), .vpos(v3),
    .hsync(hs3), .vsync(vs3), .display_on(de3), .vblank(vb3),
    .line_start(ls3), .frame_start(fs3), .frame_cnt(fc3));

  vga_timing_gen #(.H_DISPLAY(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
                   .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
                   .HSYNC_POL(1), .VSYNC_POL(1), .CLK_DIV(1), .CNT_W(11)) dutp (
    .clk(clk), .reset(resetp), .run(runp), .pix_en(pep), .hpos(hp), .vpos(vp),
    .hsync(hsp), .vsync(vsp), .display_on(dep), .vblank(vbp),
    .line_start(lsp), .frame_start(fsp), .frame_cnt(fcp));

  typedef struct packed {
    logic [10:0] h;
    logic [10:0] v;
    logic        hs;
    logic        vs;
    logic        de;
    logic        vb;
    logic [7:0]  fc;
  } reg_t;

  typedef struct packed {
    logic [10:0] h;
    logic [10:0] v;
    logic        pe;
    logic        ls;
    logic        fs;
  } dv_t;

  reg_t sb[$];
  dv_t  sb3[$];

  // Reference raster position for the base instance
  int m_h = 13, m_v = 6, m_fc = 0;
  int step_n = 0;

  function automatic reg_t model_regs();
    reg_t r;
    r.h  = 11'(m_h);
    r.v  = 11'(m_v);
    r.hs = !(m_h >= 10 && m_h < 12);
    r.vs = !(m_v == 5);
    r.de = (m_h < 8) && (m_v < 4);
    r.vb = (m_v >= 4);
    r.fc = 8'(m_fc);
    return r;
  endfunction

  // Position after n pixel strobes from reset (0 strobes = last pixel of frame).
  function automatic void pos_after(input int n, output int h, output int v);
    int p;
    if (n == 0) begin
      h = 13; v = 6;
    end else begin
      p = (n - 1) % 98;
      h = p % 14; v = p / 14;
    end
  endfunction

  // One base-instance clk: check strobes, push the model's next state, compare after the edge.
  task automatic step0(input logic r, input logic rst, output logic fs_seen);
    logic e_pe, e_ls, e_fs;
    reg_t e, g;
    run0 = r; reset0 = rst; #1;
    e_pe = r & ~rst;
    e_ls = e_pe && (m_h == 0);
    e_fs = e_ls && (m_v == 0);
    fs_seen = fs0;
    tests++;
    if ({pe0, ls0, fs0} !== {e_pe, e_ls, e_fs}) begin
      fails++;
      $display("FAIL strobes step %0d: pix_en,line_start,frame_start got %b%b%b expected %b%b%b",
               step_n, pe0, ls0, fs0, e_pe, e_ls, e_fs);
    end
    if (rst) begin
      m_h = 13; m_v = 6; m_fc = 0;
    end else if (e_pe) begin
      if (m_h == 13) begin
        m_h = 0;
        if (m_v == 6) begin
          m_v = 0; m_fc = (m_fc + 1) % 256;
        end else m_v++;
      end else m_h++;
    end
    sb.push_back(model_regs());
    @(posedge clk); #1;
    g = {h0, v0, hs0, vs0, de0, vb0, fc0};
    e = sb.pop_front();
    tests++;
    if (g !== e) begin
      fails++;
      $display("FAIL regs step %0d: got h=%0d v=%0d hs=%b vs=%b de=%b vb=%b fc=%0d expected h=%0d v=%0d hs=%b vs=%b de=%b vb=%b fc=%0d",
               step_n, g.h, g.v, g.hs, g.vs, g.de, g.vb, g.fc, e.h, e.v, e.hs, e.vs, e.de, e.vb, e.fc);
    end else begin
      $display("[TB] step %0d run=%b rst=%b h=%0d v=%0d hs=%b vs=%b fc=%0d ok",
               step_n, r, rst, g.h, g.v, g.hs, g.vs, g.fc);
    end
    step_n++;
  endtask

  task automatic test_reset();
    logic f;
    step0(1'b0, 1'b1, f);
    step0(1'b0, 1'b1, f);
    step0(1'b1, 1'b1, f);   // reset overrides run
  endtask

  task automatic test_first_pixel();
    logic f;
    step0(1'b1, 1'b0, f);
    tests++;
    if ({h0, v0, de0, fc0} !== {11'd0, 11'd0, 1'b1, 8'd1}) begin
      fails++;
      $display("FAIL first_pixel: got h=%0d v=%0d de=%b fc=%0d expected 0 0 1 1", h0, v0, de0, fc0);
    end
  endtask

  task automatic test_full_frame();
    logic f;
    int last = -1;
    for (int i = 0; i < 2 * 98 + 1; i++) begin
      step0(1'b1, 1'b0, f);
      if (f) begin
        if (last >= 0) begin
          tests++;
          if (i - last != 98) begin
            fails++;
            $display("FAIL frame_period: got %0d pix_en expected 98", i - last);
          end
        end
        last = i;
      end
    end
  endtask

  task automatic test_run_pause();
    logic f;
    int guard = 0;
    while (!(m_h == 5 && m_v == 2) && guard < 200) begin
      step0(1'b1, 1'b0, f);
      guard++;
    end
    tests++;
    if (guard >= 200) begin
      fails++;
      $display("FAIL pause_seek: got timeout expected position (5,2)");
    end
    for (int i = 0; i < 20; i++) step0(1'b0, 1'b0, f);
    step0(1'b1, 1'b0, f);
    tests++;
    if ({h0, v0} !== {11'd6, 11'd2}) begin
      fails++;
      $display("FAIL pause_resume: got h=%0d v=%0d expected h=6 v=2", h0, v0);
    end
  endtask

  task automatic test_reset_mid();
    logic f;
    int guard = 0;
    while (!(m_h == 9 && m_v == 3) && guard < 200) begin
      step0(1'b1, 1'b0, f);
      guard++;
    end
    step0(1'b1, 1'b1, f);
    tests++;
    if ({h0, v0, de0, fc0} !== {11'd13, 11'd6, 1'b0, 8'd0}) begin
      fails++;
      $display("FAIL reset_mid: got h=%0d v=%0d de=%b fc=%0d expected 13 6 0 0", h0, v0, de0, fc0);
    end
  endtask

  task automatic test_back_to_back();
    logic f;
    step0(1'b1, 1'b0, f);
    step0(1'b1, 1'b0, f);
    tests++;
    if (f !== 1'b1) begin
      fails++;
      $display("FAIL b2b_frame_start: got %b expected 1", f);
    end
  endtask

  task automatic test_clk_div();
    int eh, ev, last_ls, last_fs;
    dv_t e, g;
    logic epe;
    last_ls = -1; last_fs = -1;
    reset3 = 1'b0; run3 = 1'b1; #1;
    for (int k = 0; k < 2 * 294 + 6; k++) begin
      pos_after(k / 3, eh, ev);
      epe = (k % 3 == 2);
      sb3.push_back({11'(eh), 11'(ev), epe, epe && eh == 0, epe && eh == 0 && ev == 0});
      g = {h3, v3, pe3, ls3, fs3};
      e = sb3.pop_front();
      tests++;
      if (g !== e) begin
        fails++;
        $display("FAIL clk_div clk %0d: got h=%0d v=%0d pe=%b ls=%b fs=%b expected h=%0d v=%0d pe=%b ls=%b fs=%b",
                 k, g.h, g.v, g.pe, g.ls, g.fs, e.h, e.v, e.pe, e.ls, e.fs);
      end
      if (ls3) begin
        if (last_ls >= 0) begin
          tests++;
          if (k - last_ls != 42) begin
            fails++;
            $display("FAIL line_period: got %0d clks expected 42", k - last_ls);
          end
        end
        last_ls = k;
      end
      if (fs3) begin
        if (last_fs >= 0) begin
          tests++;
          if (k - last_fs != 294) begin
            fails++;
            $display("FAIL frame_period_div3: got %0d clks expected 294", k - last_fs);
          end
        end
        last_fs = k;
      end
      @(posedge clk); #1;
    end
    $display("[TB] clk_div test complete");
  endtask

  task automatic test_polarity_wrap();
    int eh, ev, frames;
    logic done;
    frames = 0; done = 1'b0;
    resetp = 1'b0; runp = 1'b1; #1;
    for (int c = 0; c < 30000 && !done; c++) begin
      if (c < 2 * 98) begin
        pos_after(c, eh, ev);
        tests++;
        if ({hp, vp, hsp, vsp} !== {11'(eh), 11'(ev), (eh >= 10 && eh < 12), (ev == 5)}) begin
          fails++;
          $display("FAIL polarity clk %0d: got h=%0d v=%0d hs=%b vs=%b expected h=%0d v=%0d hs=%b vs=%b",
                   c, hp, vp, hsp, vsp, eh, ev, (eh >= 10 && eh < 12), (ev == 5));
        end
      end
      if (fsp) begin
        frames++;
        if (frames == 255) begin
          tests++;
          if (fcp !== 8'd255) begin
            fails++;
            $display("FAIL frame_cnt_255: got %0d expected 255", fcp);
          end
        end
        if (frames == 256) begin
          tests++;
          if (fcp !== 8'd0 || c != 1 + 98 * 255) begin
            fails++;
            $display("FAIL frame_cnt_wrap: got fc=%0d at clk %0d expected fc=0 at clk %0d", fcp, c, 1 + 98 * 255);
          end
          done = 1'b1;
        end
      end
      if (!done) begin
        @(posedge clk); #1;
      end
    end
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL frame_wrap_timeout: got %0d frames expected 256", frames);
    end
    $display("[TB] polarity/wrap test complete");
  endtask

  initial begin
    test_reset();
    test_first_pixel();
    test_full_frame();
    test_run_pause();
    test_reset_mid();
    test_back_to_back();
    test_clk_div();
    test_polarity_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_DISPLAY, 640, active pixels per line.
REQ-002 Parameter H_FRONT, 16, horizontal front porch (pixels).
REQ-003 Parameter H_SYNC, 96, horizontal sync width (pixels).
REQ-004 Parameter H_BACK, 48, horizontal back porch (pixels).
REQ-005 Parameter V_DISPLAY, 480, active lines per frame.
REQ-006 Parameter V_FRONT, 10, vertical front porch (lines).
REQ-007 Parameter V_SYNC, 2, vertical sync width (lines).
REQ-008 Parameter V_BACK, 33, vertical back porch (lines).
REQ-009 Parameter HSYNC_POL, 0, active level of hsync (0 = active-low).
REQ-010 Parameter VSYNC_POL, 0, active level of vsync.
REQ-011 Parameter CLK_DIV, 1, clk cycles per pixel (1..16).
REQ-012 Parameter CNT_W, 11, width of hpos/vpos.
REQ-013 clk  input  1  system clock; single clock domain.
REQ-014 reset  input  1  synchronous, active-high reset.
REQ-015 run  input  1  1 = advance timing; 0 = freeze all counters.
REQ-016 pix_en  output  1  pixel strobe; counters advance on clk edges where pix_en=1.
REQ-017 hpos  output  CNT_W  current pixel column.
REQ-018 vpos  output  CNT_W  current line.
REQ-019 hsync  output  1  horizontal sync, polarity per HSYNC_POL.
REQ-020 vsync  output  1  vertical sync, polarity per VSYNC_POL.
REQ-021 display_on  output  1  hpos<H_DISPLAY and vpos<V_DISPLAY.
REQ-022 vblank  output  1  vpos>=V_DISPLAY.
REQ-023 line_start  output  1  one-pixel pulse, hpos=0.
REQ-024 frame_start  output  1  one-pixel pulse, hpos=0 and vpos=0.
REQ-025 frame_cnt  output  8  frame counter, wraps 255->0.

Function
REQ-026 H_TOTAL=H_DISPLAY+H_FRONT+H_SYNC+H_BACK; V_TOTAL likewise; both SHALL fit in CNT_W bits.
REQ-027 Divider div counts 0..CLK_DIV-1 while run=1, wraps to 0; holds while run=0.
REQ-028 pix_en = run and not reset and (div==CLK_DIV-1), combinational; with CLK_DIV=1 pix_en = run and not reset.
REQ-029 On pix_en: hpos increments; hpos==H_TOTAL-1 -> hpos=0 and vpos increments; vpos==V_TOTAL-1 at that wrap -> vpos=0.
REQ-030 hsync active iff H_DISPLAY+H_FRONT <= hpos < H_DISPLAY+H_FRONT+H_SYNC.
REQ-031 vsync active iff V_DISPLAY+V_FRONT <= vpos < V_DISPLAY+V_FRONT+V_SYNC.
REQ-032 hsync, vsync, display_on, vblank, line_start, frame_start registered, valid in the same cycle as their hpos/vpos (zero relative latency, no glitches).
REQ-033 line_start/frame_start high for exactly the clk cycles in which the pixel position is (0,y)/(0,0) and pix_en=1 (one clk per pixel).
REQ-034 frame_cnt increments in the clk cycle the counters enter (0,0).
REQ-035 run=0 mid-line: hpos, vpos, div, sync levels, frame_cnt hold; pulses deassert; resume continues from the held position.

Reset
REQ-036 reset=1 at a clk edge: div=0, hpos=H_TOTAL-1, vpos=V_TOTAL-1, hsync=!HSYNC_POL, vsync=!VSYNC_POL, display_on=0, vblank=1, line_start=0, frame_start=0, frame_cnt=0.
REQ-037 Reset SHALL override run and take effect mid-frame; first pix_en after release moves to (0,0), asserting line_start, frame_start and incrementing frame_cnt to 1.

Verification
REQ-038 Parameter set H=8/2/2/2, V=4/1/1/1, CLK_DIV=1, run=1 after reset: hpos cycles 0..13, hsync low exactly at hpos 10,11, vpos cycles 0..6, vsync low exactly at vpos 5.
REQ-039 Same set, CLK_DIV=3: pix_en high every 3rd clk; each hpos value lasts 3 clks; line period 42 clks, frame period 294 clks.
REQ-040 Reset release -> first pix_en: hpos=0, vpos=0, frame_start=1, line_start=1, frame_cnt=1, display_on=1; frame_start recurs every 98 pix_en.
REQ-041 run=0 held 20 clks at hpos=5, vpos=2 -> hpos/vpos/frame_cnt unchanged, pix_en=0; run=1 -> next pix_en gives hpos=6.
REQ-042 HSYNC_POL=VSYNC_POL=1 -> sync idle low, high only in sync windows; 256 frames -> frame_cnt wraps to 0.
REQ-043 reset pulsed at hpos=9, vpos=3 -> next cycle hpos=13, vpos=6, display_on=0, frame_cnt=0.
